// File: rtl/if_id_buf_if.sv
// Purpose: fetch-to-decode buffer bus. Bundles the fetch push side, the decode
//          pop side, the flush request and the occupancy report.
// Signals:
//   if_valid_i/if_pc_i/if_inst_i  fetch offers a {pc, inst} pair
//   if_ready_o                    buffer can take a push this cycle
//   id_valid_o/id_pc_o/id_inst_o  head entry presented to decode
//   id_ready_i                    decode consumes the head entry
//   flush_i                       discard all buffered entries
//   count_o                       current occupancy, 0..DEPTH
// Modports: slave = buffer side, master = fetch/decode environment side.
interface if_id_buf_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 2
) ();
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              if_valid_i;
  logic [ADDR_W-1:0] if_pc_i;
  logic [INST_W-1:0] if_inst_i;
  logic              if_ready_o;
  logic              id_valid_o;
  logic [ADDR_W-1:0] id_pc_o;
  logic [INST_W-1:0] id_inst_o;
  logic              id_ready_i;
  logic              flush_i;
  logic [CNT_W-1:0]  count_o;

  modport slave (
    input  if_valid_i, if_pc_i, if_inst_i, id_ready_i, flush_i,
    output if_ready_o, id_valid_o, id_pc_o, id_inst_o, count_o
  );

  modport master (
    output if_valid_i, if_pc_i, if_inst_i, id_ready_i, flush_i,
    input  if_ready_o, id_valid_o, id_pc_o, id_inst_o, count_o
  );
endinterface

// File: rtl/if_id_buf.sv
// Purpose: circular buffer between instruction fetch and decode with
//          valid/ready handshakes on both sides and a flush for taken branches.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  if_id_buf_if.slave (fetch push, decode pop, flush, occupancy)
// Notes: if_ready_o depends only on the registered count, so a full buffer
//        never passes a word through in the same cycle as a pop. Decode
//        outputs come straight from storage, never from the fetch inputs.
module if_id_buf #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  if_id_buf_if.slave  bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  // Flush overrides both sides, so the fetched word that cycle is dropped.
  assign w_push  = bus.if_valid_i & ~w_full  & ~bus.flush_i;
  assign w_pop   = bus.id_ready_i & ~w_empty & ~bus.flush_i;

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_pc_mem[i]   <= '0;
        r_inst_mem[i] <= '0;
      end
    end else if (bus.flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wr_ptr]   <= bus.if_pc_i;
        r_inst_mem[r_wr_ptr] <= bus.if_inst_i;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Decode side sees zeros when empty so a stray consume decodes as a NOP.
  assign bus.if_ready_o = ~w_full;
  assign bus.id_valid_o = ~w_empty;
  assign bus.id_pc_o    = w_empty ? '0 : r_pc_mem[r_rd_ptr];
  assign bus.id_inst_o  = w_empty ? '0 : r_inst_mem[r_rd_ptr];
  assign bus.count_o    = r_count;
endmodule

// File: tb/tb_if_id_buf.sv
// Purpose: directed self-checking bench for if_id_buf (DEPTH=2).
module tb_if_id_buf;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [31:0] q[$];

  if_id_buf_if #(.ADDR_W(32), .INST_W(32), .DEPTH(2)) bus ();

  if_id_buf #(.ADDR_W(32), .INST_W(32), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    bus.if_valid_i = v;
    bus.if_pc_i    = pc;
    bus.if_inst_i  = inst_of(pc);
    bus.id_ready_i = rdy;
    bus.flush_i    = fl;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(1'b1, 32'h100, 1'b1, 1'b0);

    // 1. reset held with fetch valid
    #12;
    check("rst_id_valid", 32'(bus.id_valid_o), 32'd0);
    check("rst_if_ready", 32'(bus.if_ready_o), 32'd1);
    check("rst_count",    32'(bus.count_o),    32'd0);
    check("rst_id_pc",    bus.id_pc_o,         32'h0);
    check("rst_id_inst",  bus.id_inst_o,       32'h0);

    // 2. streaming with decode always ready
    rst = 1'b0;
    drive(1'b1, 32'h0, 1'b1, 1'b0);
    tick();
    check("s0_pc",    bus.id_pc_o,         32'h0);
    check("s0_inst",  bus.id_inst_o,       32'hC0DE0000);
    check("s0_count", 32'(bus.count_o),    32'd1);
    drive(1'b1, 32'h4, 1'b1, 1'b0);
    tick();
    check("s1_pc",    bus.id_pc_o,         32'h4);
    check("s1_count", 32'(bus.count_o),    32'd1);
    drive(1'b1, 32'h8, 1'b1, 1'b0);
    tick();
    check("s2_pc",    bus.id_pc_o,         32'h8);
    check("s2_inst",  bus.id_inst_o,       32'hC0DE0008);
    check("s2_count", 32'(bus.count_o),    32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check("s3_valid", 32'(bus.id_valid_o), 32'd0);
    check("s3_pc",    bus.id_pc_o,         32'h0);

    // 3. stall until full, third push refused, then drain in order
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    tick();
    check("f1_count", 32'(bus.count_o),    32'd1);
    check("f1_ready", 32'(bus.if_ready_o), 32'd1);
    drive(1'b1, 32'h14, 1'b0, 1'b0);
    tick();
    check("f2_count", 32'(bus.count_o),    32'd2);
    check("f2_ready", 32'(bus.if_ready_o), 32'd0);
    drive(1'b1, 32'h18, 1'b0, 1'b0);
    tick();
    check("f3_count", 32'(bus.count_o),    32'd2);
    check("f3_head",  bus.id_pc_o,         32'h10);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check("d1_pc",    bus.id_pc_o,         32'h14);
    check("d1_inst",  bus.id_inst_o,       32'hC0DE0014);
    check("d1_count", 32'(bus.count_o),    32'd1);
    tick();
    check("d2_count", 32'(bus.count_o),    32'd0);
    check("d2_valid", 32'(bus.id_valid_o), 32'd0);

    // 4. flush with fetch valid; flush also beats a push into an empty buffer
    drive(1'b1, 32'h20, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h24, 1'b0, 1'b0);
    tick();
    check("fl_pre_count", 32'(bus.count_o), 32'd2);
    drive(1'b1, 32'h28, 1'b1, 1'b1);
    tick();
    check("fl_count", 32'(bus.count_o),    32'd0);
    check("fl_valid", 32'(bus.id_valid_o), 32'd0);
    check("fl_ready", 32'(bus.if_ready_o), 32'd1);
    drive(1'b1, 32'h30, 1'b0, 1'b1);
    tick();
    check("fl_push_count", 32'(bus.count_o), 32'd0);
    drive(1'b0, 32'h28, 1'b1, 1'b0);
    tick();
    check("fl_post_valid", 32'(bus.id_valid_o), 32'd0);
    check("fl_post_pc",    bus.id_pc_o,         32'h0);

    // 5. pointer wrap at alternating push/pop rates, checked against a queue model
    q.delete();
    begin
      logic [31:0] next_pc;
      logic        v;
      logic        r;
      next_pc = 32'h40;
      for (int i = 0; i < 10; i++) begin
        v = (i % 3) != 2;
        r = (i % 2) == 0;
        drive(v, next_pc, r, 1'b0);
        #1;
        check("w_count", 32'(bus.count_o),    32'(q.size()));
        check("w_valid", 32'(bus.id_valid_o), 32'(q.size() != 0));
        if (q.size() != 0) check("w_head", bus.id_pc_o, q[0]);
        if (r && q.size() != 0) void'(q.pop_front());
        else r = 1'b0;
        if (v && (q.size() + (r ? 1 : 0)) < 2) begin
          q.push_back(next_pc);
          next_pc = next_pc + 32'h4;
        end
        tick();
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      while (q.size() != 0) begin
        #1;
        check("w_drain", bus.id_pc_o, q[0]);
        void'(q.pop_front());
        tick();
      end
      check("w_end_count", 32'(bus.count_o), 32'd0);
    end

    // 6. async reset pulse between edges with the buffer full
    drive(1'b1, 32'h50, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h54, 1'b0, 1'b0);
    tick();
    check("ar_pre_count", 32'(bus.count_o), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("ar_count", 32'(bus.count_o),    32'd0);
    check("ar_valid", 32'(bus.id_valid_o), 32'd0);
    check("ar_pc",    bus.id_pc_o,         32'h0);
    check("ar_ready", 32'(bus.if_ready_o), 32'd1);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("ar_post_count", 32'(bus.count_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
